// File: rtl/alu_arbiter_if.sv
// Request/response/ALU bus of alu_arbiter; the arbiter uses the slave
// modport, requesters plus the shared ALU model use the master modport.
interface alu_arbiter_if #(
  parameter int WIDTH = 32
);
  logic             req0_valid_i;
  logic             req1_valid_i;
  logic             req0_ready_o;
  logic             req1_ready_o;
  logic [2:0]       req0_ctrl_i;
  logic [2:0]       req1_ctrl_i;
  logic [WIDTH-1:0] req0_data1_i;
  logic [WIDTH-1:0] req0_data2_i;
  logic [WIDTH-1:0] req1_data1_i;
  logic [WIDTH-1:0] req1_data2_i;
  logic             resp0_valid_o;
  logic             resp1_valid_o;
  logic [WIDTH-1:0] resp0_data_o;
  logic [WIDTH-1:0] resp1_data_o;
  logic             resp0_zero_o;
  logic             resp1_zero_o;
  logic [2:0]       alu_ctrl_o;
  logic [WIDTH-1:0] alu_data1_o;
  logic [WIDTH-1:0] alu_data2_o;
  logic [WIDTH-1:0] alu_data_i;
  logic             alu_zero_i;
  logic             busy_o;

  modport slave (
    input  req0_valid_i, req1_valid_i, req0_ctrl_i, req1_ctrl_i,
    input  req0_data1_i, req0_data2_i, req1_data1_i, req1_data2_i,
    input  alu_data_i, alu_zero_i,
    output req0_ready_o, req1_ready_o,
    output resp0_valid_o, resp1_valid_o, resp0_data_o, resp1_data_o,
    output resp0_zero_o, resp1_zero_o,
    output alu_ctrl_o, alu_data1_o, alu_data2_o, busy_o
  );

  modport master (
    output req0_valid_i, req1_valid_i, req0_ctrl_i, req1_ctrl_i,
    output req0_data1_i, req0_data2_i, req1_data1_i, req1_data2_i,
    output alu_data_i, alu_zero_i,
    input  req0_ready_o, req1_ready_o,
    input  resp0_valid_o, resp1_valid_o, resp0_data_o, resp1_data_o,
    input  resp0_zero_o, resp1_zero_o,
    input  alu_ctrl_o, alu_data1_o, alu_data2_o, busy_o
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one ALU between two requesters; Mul ops occupy the
// ALU for MUL_LAT cycles, everything else for one, results return as a pulse.
module alu_arbiter #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  alu_arbiter_if.slave bus
);
  localparam logic [2:0] OP_MUL = 3'd3;
  localparam int         CNT_W  = ($clog2(MUL_LAT) < 2) ? 2 : $clog2(MUL_LAT);
  localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);

  typedef enum logic {ST_IDLE, ST_EXEC} state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_last_grant;
  logic             r_owner;
  logic [2:0]       r_op_ctrl;
  logic [WIDTH-1:0] r_op_data1;
  logic [WIDTH-1:0] r_op_data2;
  logic             r_resp0_valid;
  logic             r_resp1_valid;
  logic [WIDTH-1:0] r_resp0_data;
  logic [WIDTH-1:0] r_resp1_data;
  logic             r_resp0_zero;
  logic             r_resp1_zero;

  logic             w_grant_en;
  logic             w_grant_port;
  logic [2:0]       w_ctrl;
  logic [WIDTH-1:0] w_data1;
  logic [WIDTH-1:0] w_data2;

  // NOTE: every signal assigned in always_comb gets a default first so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    w_grant_port = 1'b0;
    if (bus.req0_valid_i && bus.req1_valid_i) w_grant_port = ~r_last_grant;
    else if (bus.req1_valid_i)                w_grant_port = 1'b1;
    // rst_i gates the grant so no ready leaks out while reset is held.
    w_grant_en = rst_i && (r_state == ST_IDLE) &&
                 (bus.req0_valid_i || bus.req1_valid_i);
    w_ctrl  = w_grant_port ? bus.req1_ctrl_i  : bus.req0_ctrl_i;
    w_data1 = w_grant_port ? bus.req1_data1_i : bus.req0_data1_i;
    w_data2 = w_grant_port ? bus.req1_data2_i : bus.req0_data2_i;
  end

  assign bus.req0_ready_o  = w_grant_en && !w_grant_port;
  assign bus.req1_ready_o  = w_grant_en &&  w_grant_port;
  assign bus.alu_ctrl_o    = r_op_ctrl;
  assign bus.alu_data1_o   = r_op_data1;
  assign bus.alu_data2_o   = r_op_data2;
  assign bus.busy_o        = (r_state == ST_EXEC);
  assign bus.resp0_valid_o = r_resp0_valid;
  assign bus.resp1_valid_o = r_resp1_valid;
  assign bus.resp0_data_o  = r_resp0_data;
  assign bus.resp1_data_o  = r_resp1_data;
  assign bus.resp0_zero_o  = r_resp0_zero;
  assign bus.resp1_zero_o  = r_resp1_zero;

  // NOTE: state is updated only with non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state       <= ST_IDLE;
      r_cnt         <= '0;
      r_last_grant  <= 1'b1;
      r_owner       <= 1'b0;
      r_op_ctrl     <= '0;
      r_op_data1    <= '0;
      r_op_data2    <= '0;
      r_resp0_valid <= 1'b0;
      r_resp1_valid <= 1'b0;
      r_resp0_data  <= '0;
      r_resp1_data  <= '0;
      r_resp0_zero  <= 1'b0;
      r_resp1_zero  <= 1'b0;
    end else begin
      r_resp0_valid <= 1'b0;
      r_resp1_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_grant_en) begin
            r_op_ctrl    <= w_ctrl;
            r_op_data1   <= w_data1;
            r_op_data2   <= w_data2;
            r_last_grant <= w_grant_port;
            r_owner      <= w_grant_port;
            r_cnt        <= (w_ctrl == OP_MUL) ? MUL_CNT : '0;
            r_state      <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else begin
            if (r_owner) begin
              r_resp1_valid <= 1'b1;
              r_resp1_data  <= bus.alu_data_i;
              r_resp1_zero  <= bus.alu_zero_i;
            end else begin
              r_resp0_valid <= 1'b1;
              r_resp0_data  <= bus.alu_data_i;
              r_resp0_zero  <= bus.alu_zero_i;
            end
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a combinational model of the shared ALU.
module tb_alu_arbiter;
  localparam int WIDTH   = 32;
  localparam int MUL_LAT = 4;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;

  alu_arbiter_if #(.WIDTH(WIDTH)) bus ();

  alu_arbiter #(.WIDTH(WIDTH), .MUL_LAT(MUL_LAT)) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared ALU model.
  logic [WIDTH-1:0] alu_res;
  always_comb begin
    alu_res = '0;
    case (bus.alu_ctrl_o)
      3'd0: alu_res = bus.alu_data1_o & bus.alu_data2_o;
      3'd1: alu_res = bus.alu_data1_o | bus.alu_data2_o;
      3'd2: alu_res = bus.alu_data1_o + bus.alu_data2_o;
      3'd3: alu_res = bus.alu_data1_o * bus.alu_data2_o;
      3'd6: alu_res = bus.alu_data1_o - bus.alu_data2_o;
      3'd7: alu_res = ($signed(bus.alu_data1_o) < $signed(bus.alu_data2_o)) ? 1 : 0;
      default: alu_res = '0;
    endcase
    bus.alu_data_i = alu_res;
    bus.alu_zero_i = (alu_res == '0);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input int p, input logic v, input logic [2:0] c,
                       input logic [31:0] a, input logic [31:0] b);
    if (p == 0) begin
      bus.req0_valid_i = v; bus.req0_ctrl_i = c;
      bus.req0_data1_i = a; bus.req0_data2_i = b;
    end else begin
      bus.req1_valid_i = v; bus.req1_ctrl_i = c;
      bus.req1_data1_i = a; bus.req1_data2_i = b;
    end
  endtask

  function automatic logic ready_of(input int p);
    return (p == 0) ? bus.req0_ready_o : bus.req1_ready_o;
  endfunction

  function automatic logic rvalid_of(input int p);
    return (p == 0) ? bus.resp0_valid_o : bus.resp1_valid_o;
  endfunction

  // Single op from one port while the other is idle; lat = EXEC cycles.
  task automatic run_op(input string tag, input int p, input logic [2:0] c,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_d, input logic exp_z, input int lat);
    drive(p, 1'b1, c, a, b);
    #1;
    check({tag, "_ready"}, ready_of(p), 1'b1);
    tick();
    drive(p, 1'b0, 3'd0, 0, 0);
    for (int i = 0; i < lat; i++) begin
      check({tag, "_busy"}, bus.busy_o, 1'b1);
      tick();
    end
    check({tag, "_rvalid"}, rvalid_of(p), 1'b1);
    check({tag, "_rother"}, rvalid_of(1 - p), 1'b0);
    check({tag, "_data"}, (p == 0) ? bus.resp0_data_o : bus.resp1_data_o, exp_d);
    check({tag, "_zero"}, (p == 0) ? bus.resp0_zero_o : bus.resp1_zero_o, exp_z);
    check({tag, "_idle"}, bus.busy_o, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 1'b1, 3'd2, 5, 7);
    drive(1, 1'b1, 3'd2, 1, 1);

    // Reset held with both requests pending.
    tick(); tick();
    check("rst_ready0", bus.req0_ready_o, 1'b0);
    check("rst_ready1", bus.req1_ready_o, 1'b0);
    check("rst_busy", bus.busy_o, 1'b0);
    check("rst_rv0", bus.resp0_valid_o, 1'b0);
    check("rst_rv1", bus.resp1_valid_o, 1'b0);
    check("rst_rd0", bus.resp0_data_o, 0);
    check("rst_rz1", bus.resp1_zero_o, 1'b0);
    check("rst_alu_ctrl", bus.alu_ctrl_o, 0);
    check("rst_alu_d1", bus.alu_data1_o, 0);
    rst_n = 1'b1;
    #1;
    check("rel_ready0", bus.req0_ready_o, 1'b1);
    check("rel_ready1", bus.req1_ready_o, 1'b0);
    drive(0, 1'b0, 3'd0, 0, 0);
    drive(1, 1'b0, 3'd0, 0, 0);
    tick();

    run_op("add0", 0, 3'd2, 5, 7, 12, 1'b0, 1);
    tick();
    check("hold_rv0", bus.resp0_valid_o, 1'b0);
    check("hold_rd0", bus.resp0_data_o, 12);

    // Port 1 Mul with a port 0 request raised mid-op.
    drive(1, 1'b1, 3'd3, 3, 4);
    #1;
    check("mul_ready1", bus.req1_ready_o, 1'b1);
    tick();
    drive(1, 1'b0, 3'd0, 0, 0);
    drive(0, 1'b1, 3'd2, 1, 1);
    for (int i = 0; i < MUL_LAT; i++) begin
      check("mul_busy", bus.busy_o, 1'b1);
      check("mul_wait_ready0", bus.req0_ready_o, 1'b0);
      check("mul_rv1_early", bus.resp1_valid_o, 1'b0);
      tick();
    end
    check("mul_rv1", bus.resp1_valid_o, 1'b1);
    check("mul_rd1", bus.resp1_data_o, 12);
    check("mul_busy_end", bus.busy_o, 1'b0);
    check("mul_ready0", bus.req0_ready_o, 1'b1);
    tick();
    drive(0, 1'b0, 3'd0, 0, 0);
    check("b2b_busy", bus.busy_o, 1'b1);
    tick();
    check("b2b_rv0", bus.resp0_valid_o, 1'b1);
    check("b2b_rd0", bus.resp0_data_o, 2);

    // Both ports continuously valid: last grant was 0, so 1,0,1,0.
    drive(0, 1'b1, 3'd2, 10, 1);
    drive(1, 1'b1, 3'd2, 20, 2);
    #1;
    for (int k = 0; k < 4; k++) begin
      int e;
      int prv;
      e   = (k % 2 == 0) ? 1 : 0;
      prv = 1 - e;
      check("rr_ready0", bus.req0_ready_o, e == 0);
      check("rr_ready1", bus.req1_ready_o, e == 1);
      if (k > 0) begin
        check("rr_rv_prev", rvalid_of(prv), 1'b1);
        check("rr_rv_cur", rvalid_of(e), 1'b0);
        check("rr_rd_prev", (prv == 0) ? bus.resp0_data_o : bus.resp1_data_o,
              (prv == 0) ? 32'd11 : 32'd22);
      end
      tick();
      check("rr_busy", bus.busy_o, 1'b1);
      check("rr_noready", bus.req0_ready_o | bus.req1_ready_o, 1'b0);
      tick();
    end
    drive(0, 1'b0, 3'd0, 0, 0);
    drive(1, 1'b0, 3'd0, 0, 0);
    check("rr_last_rv0", bus.resp0_valid_o, 1'b1);
    check("rr_last_rd0", bus.resp0_data_o, 11);
    tick();

    run_op("sub0", 0, 3'd6, 9, 9, 0, 1'b1, 1);
    tick();
    run_op("op4_1", 1, 3'd4, 1, 2, 0, 1'b1, 1);
    tick();
    run_op("and0", 0, 3'd0, 32'hF0F0, 32'hFF00, 32'hF000, 1'b0, 1);
    tick();
    run_op("slt1", 1, 3'd7, 32'hFFFF_FFFF, 1, 1, 1'b0, 1);
    tick();

    // Reset in the middle of a port 0 Mul.
    drive(0, 1'b1, 3'd3, 2, 3);
    #1;
    check("abort_ready0", bus.req0_ready_o, 1'b1);
    tick();
    drive(0, 1'b0, 3'd0, 0, 0);
    tick();
    check("abort_busy_pre", bus.busy_o, 1'b1);
    rst_n = 1'b0;
    #1;
    check("abort_busy", bus.busy_o, 1'b0);
    check("abort_rv0", bus.resp0_valid_o, 1'b0);
    check("abort_alu_d1", bus.alu_data1_o, 0);
    tick();
    check("abort_rv0_late", bus.resp0_valid_o, 1'b0);
    rst_n = 1'b1;
    drive(0, 1'b1, 3'd2, 4, 4);
    drive(1, 1'b1, 3'd2, 1, 1);
    #1;
    check("post_ready0", bus.req0_ready_o, 1'b1);
    check("post_ready1", bus.req1_ready_o, 1'b0);
    tick();
    drive(0, 1'b0, 3'd0, 0, 0);
    drive(1, 1'b0, 3'd0, 0, 0);
    check("post_busy", bus.busy_o, 1'b1);
    tick();
    check("post_rv0", bus.resp0_valid_o, 1'b1);
    check("post_rv1", bus.resp1_valid_o, 1'b0);
    check("post_rd0", bus.resp0_data_o, 8);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
